// File: rtl/rand_draw_pkg.sv
// Shared constants and the channel-offset wrap helper for rand_draw_bank.
package rand_draw_pkg;

  localparam int unsigned DRAW_CNT_W = 4;
  localparam logic [DRAW_CNT_W-1:0] DRAW_CNT_MAX = 4'd15;

  // base + k folded back into [mn..mx]; base <= mx and k < range, so one fold suffices.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned k,
                                           input int unsigned mn, input int unsigned mx);
    int unsigned sum;
    sum = base + k;
    if (sum > mx) sum = sum - (mx - mn + 1);
    return sum;
  endfunction

endpackage

// File: rtl/draw_sync.sv
// Push-button front end: 2-flop synchronizer and falling-edge detector (one hit per press).
module draw_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_n,
  output logic hit
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= btn_n;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign hit = r_prev & ~r_s2;

endmodule

// File: rtl/rand_draw_bank.sv
// Multi-channel random draw generator: free-running MIN..MAX counter sampled on button presses.
// Optional per-channel saturating draw counters are built when RAND_DRAW_COUNT_EN is defined.
module rand_draw_bank
  import rand_draw_pkg::*;
#(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned MIN      = 1,
  parameter int unsigned MAX      = 31,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             clear,
  input  logic [CHANNELS-1:0]              draw_n,
  output logic [CHANNELS*WIDTH-1:0]        q,
  output logic [CHANNELS-1:0]              valid,
  output logic [CHANNELS*DRAW_CNT_W-1:0]   draw_count
);

  logic [WIDTH-1:0]                 r_cnt;
  logic [CHANNELS-1:0]              w_hit;
  logic [CHANNELS-1:0][WIDTH-1:0]   w_off;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_q;
  logic [CHANNELS-1:0]              r_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= WIDTH'(MIN);
    end else if (enable) begin
      r_cnt <= (r_cnt == WIDTH'(MAX)) ? WIDTH'(MIN) : r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    draw_sync u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_n   (draw_n[g]),
      .hit     (w_hit[g])
    );
  end

  // Lower-indexed simultaneous hits each claim one step, keeping same-cycle draws distinct.
  always_comb begin
    int unsigned v_k;
    v_k   = 0;
    w_off = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_off[i] = WIDTH'(wrap_add(32'(r_cnt), v_k, MIN, MAX));
      if (w_hit[i]) v_k++;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_valid <= '0;
    end else if (clear) begin
      r_q     <= '0;
      r_valid <= '0;
    end else begin
      r_valid <= w_hit;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_hit[i]) r_q[i] <= w_off[i];
      end
    end
  end

  assign q     = r_q;
  assign valid = r_valid;

`ifdef RAND_DRAW_COUNT_EN
  logic [CHANNELS-1:0][DRAW_CNT_W-1:0] r_dcnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dcnt <= '0;
    end else if (clear) begin
      r_dcnt <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_hit[i] && r_dcnt[i] != DRAW_CNT_MAX) r_dcnt[i] <= r_dcnt[i] + 1'b1;
      end
    end
  end

  assign draw_count = r_dcnt;
`else
  assign draw_count = '0;
`endif

endmodule

// File: tb/tb_rand_draw_bank.sv
// Directed bench for rand_draw_bank (CHANNELS=2, WIDTH=5, MIN=1, MAX=31); works with or without RAND_DRAW_COUNT_EN.
module tb_rand_draw_bank;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic [1:0] draw_n;
  logic [9:0] q;
  logic [1:0] valid;
  logic [7:0] draw_count;

  int n_checks;
  int n_fail;

  rand_draw_bank #(.WIDTH(5), .MIN(1), .MAX(31), .CHANNELS(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .draw_n     (draw_n),
    .q          (q),
    .valid      (valid),
    .draw_count (draw_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         adv;
    logic [1:0] mask;
    logic [4:0] q0;
    logic [4:0] q1;
    logic [1:0] vld;
    logic [3:0] c0;
    logic [3:0] c1;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [3:0] exp_cnt(input logic [3:0] v);
`ifdef RAND_DRAW_COUNT_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    draw_n  = 2'b11;
    clear   = 1'b0;
    enable  = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic advance(input int n);
    if (n > 0) begin
      enable = 1'b1;
      step(n);
      enable = 1'b0;
    end
  endtask

  // Press, wait until the sample after E2, leave button held.
  task automatic press(input logic [1:0] mask);
    draw_n = ~mask;
    step(3);
  endtask

  task automatic release_all();
    draw_n = 2'b11;
    step(3);
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{adv: 0,  mask: 2'b01, q0: 5'd1,  q1: 5'd0,  vld: 2'b01, c0: 4'd1, c1: 4'd0};
    vecs[1] = '{adv: 4,  mask: 2'b10, q0: 5'd1,  q1: 5'd5,  vld: 2'b10, c0: 4'd1, c1: 4'd1};
    vecs[2] = '{adv: 25, mask: 2'b11, q0: 5'd30, q1: 5'd31, vld: 2'b11, c0: 4'd2, c1: 4'd2};
    vecs[3] = '{adv: 1,  mask: 2'b11, q0: 5'd31, q1: 5'd1,  vld: 2'b11, c0: 4'd3, c1: 4'd3};
    vecs[4] = '{adv: 1,  mask: 2'b10, q0: 5'd31, q1: 5'd1,  vld: 2'b10, c0: 4'd3, c1: 4'd4};
    vecs[5] = '{adv: 10, mask: 2'b01, q0: 5'd11, q1: 5'd1,  vld: 2'b01, c0: 4'd4, c1: 4'd4};

    do_reset();
    chk("reset_q", 32'(q), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_count", 32'(draw_count), 0);

    // First draw latency: valid rises exactly at the sample after E2
    draw_n = 2'b10;
    step(1);
    chk("lat_valid_E0", 32'(valid), 0);
    step(1);
    chk("lat_valid_E1", 32'(valid), 0);
    step(1);
    chk("lat_valid_E2", 32'(valid), 32'b01);
    chk("lat_q0", 32'(q[4:0]), 1);
    step(1);
    chk("lat_valid_E3", 32'(valid), 0);
    release_all();

    // Table-driven draws; counter carried across vectors
    do_reset();
    foreach (vecs[i]) begin
      advance(vecs[i].adv);
      press(vecs[i].mask);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d_q0", i), 32'(q[4:0]), 32'(vecs[i].q0));
      chk($sformatf("v%0d_q1", i), 32'(q[9:5]), 32'(vecs[i].q1));
      chk($sformatf("v%0d_c0", i), 32'(draw_count[3:0]), 32'(exp_cnt(vecs[i].c0)));
      chk($sformatf("v%0d_c1", i), 32'(draw_count[7:4]), 32'(exp_cnt(vecs[i].c1)));
      step(1);
      chk($sformatf("v%0d_valid_off", i), 32'(valid), 0);
      release_all();
    end

    // Counter reaches MAX after 30 clocks, wraps to MIN after 31
    do_reset();
    advance(30);
    press(2'b01);
    chk("wrap30_q0", 32'(q[4:0]), 31);
    release_all();
    do_reset();
    advance(31);
    press(2'b01);
    chk("wrap31_q0", 32'(q[4:0]), 1);
    release_all();

    // Held button gives exactly one pulse
    do_reset();
    draw_n = 2'b01;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (valid[1]) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 1);
    chk("hold_valid0", 32'(valid), 0);
    release_all();

    // Clear in the capture cycle wins
    do_reset();
    advance(6);
    press(2'b11);
    release_all();
    draw_n = 2'b10;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_valid", 32'(valid), 0);
    chk("clr_q", 32'(q), 0);
    chk("clr_count", 32'(draw_count), 0);
    step(1);
    chk("clr_valid_after", 32'(valid), 0);
    release_all();
    press(2'b01);
    chk("post_clr_valid", 32'(valid), 32'b01);
    chk("post_clr_q0", 32'(q[4:0]), 7);
    chk("post_clr_c0", 32'(draw_count[3:0]), 32'(exp_cnt(4'd1)));
    release_all();

    // Saturation of the draw counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      press(2'b01);
      release_all();
    end
    chk("sat_c0", 32'(draw_count[3:0]), 32'(exp_cnt(4'd15)));
    chk("sat_c1", 32'(draw_count[7:4]), 0);
    chk("sat_q0", 32'(q[4:0]), 1);

    // Async reset mid-draw drops the pending hit
    do_reset();
    advance(5);
    draw_n = 2'b10;
    step(2);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_q", 32'(q), 0);
    chk("rst_mid_valid", 32'(valid), 0);
    draw_n = 2'b11;
    step(2);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (valid != 2'b00) pulses++;
    end
    chk("rst_mid_pulses", 32'(pulses), 0);
    press(2'b01);
    chk("rst_mid_counter_min", 32'(q[4:0]), 1);
    release_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
